shift_reg_n: RTL and testbench
==============================

# shift_reg_n

Parametrised universal shift register: the next generation of the 8-bit shift register, generalised to WIDTH bits. It adds a registered serial output, a shift counter with a frame-done pulse, and a synchronous clear. It sits between serial links and parallel datapaths (SPI-like deserialiser/serialiser, LED/IO expanders) and is reusable at any width.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; not overridden).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous clear of register and counter.
- mode_i  in  2  0 HOLD, 1 LOAD, 2 LEFT, 3 RIGHT.
- D  in  1  serial input bit.
- rot_i  in  1  rotate select; only used when SHIFT_REG_N_ROTATE_EN is defined.
- par_i  in  WIDTH  parallel load data.
- P  out  WIDTH  parallel register contents.
- so_o  out  1  last bit shifted out of the register (registered).
- cnt_o  out  CNT_W  shifts since the last load, clear or frame wrap.
- done_o  out  1  one-cycle pulse when the WIDTH-th shift of a frame completes.

## Operation
- Priority per edge: rst > clear_i > mode_i.
- rst or clear_i: P=0, so_o=0, cnt_o=0, done_o=0.
- HOLD: P, so_o and cnt_o are unchanged; done_o=0.
- LOAD: P=par_i; cnt_o=0; so_o unchanged; done_o=0.
- LEFT: P={P[WIDTH-2:0], D}; so_o=old P[WIDTH-1].
- RIGHT: P={D, P[WIDTH-1:1]}; so_o=old P[0].
- Shift counting (LEFT/RIGHT only): if cnt_o==WIDTH-1 then cnt_o=0 and done_o=1 on the following cycle; otherwise cnt_o+1 and done_o=0.
- Mixing LEFT and RIGHT within a frame is legal. Each shift counts.
- Direction change does not reset the counter.
- clear_i on the same edge as a shift overrides the shift: P=0, cnt_o=0, no done_o.

## Timing
- All outputs are registered and update on the rising edge where the operation is sampled. There is no combinational path from input to output.
- Latency of LOAD and shift: 1 cycle.
- done_o is high for exactly the one cycle after the WIDTH-th shift edge. P then holds the complete frame.
- Back-to-back frames: continuous shifting gives one done_o every WIDTH cycles with no gap cycle.
- Reset mid-frame discards the partial frame. The counter restarts at 0 after reset deassertion.
- Reset values: P=0, so_o=0, cnt_o=0, done_o=0.
- mode_i=LOAD while rst=1 has no effect.

## Configuration
- Macro: SHIFT_REG_N_ROTATE_EN.
- Defined: when rot_i=1 during LEFT, P={P[WIDTH-2:0], P[WIDTH-1]}; during RIGHT, P={P[0], P[WIDTH-1:1]}. D is ignored. so_o and counter behave as for a normal shift.
- Not defined: rot_i is present but ignored. Shifts always take D.

## Structure
- Package shift_reg_n_pkg holds:
  - enum mode_t {MODE_HOLD=2'd0, MODE_LOAD=2'd1, MODE_LEFT=2'd2, MODE_RIGHT=2'd3};
  - localparam MAX_WIDTH=64.
- Sub-module shift_reg_n_cnt holds the frame counter and done pulse. Inputs: clk, rst, clr (clear or load), inc (shift). Parameter WIDTH.
- The data register and so_o live in the top module.

## Test plan
- Reset: drive rst=1 with mode_i=LOAD, par_i=8'h77 for 2 edges -> P=8'h00, cnt_o=0, done_o=0, so_o=0. Hold rst=0 and mode_i=HOLD for 1 edge -> P still 8'h00.
- LEFT frame, WIDTH=8: stream D=1,0,1,0,1,0,1,0 -> P=8'hAA. done_o is high exactly once, the cycle after the 8th edge. cnt_o is then 0.
- RIGHT frame: after LOAD par_i=8'hC3, stream 8 zeros -> P=8'h00. so_o sequence reads 1,1,0,0,0,0,1,1. done_o pulses once.
- Continuous shifting with WIDTH=4 for 12 edges -> done_o pulses after edges 4, 8 and 12, with no gaps. A 10-bit LEFT stream 1,0,1,0,1,0,1,0,1,1 on WIDTH=8 -> P=8'hAB, cnt_o=2.
- Boundary cases:
  - clear_i asserted on the same edge as the 8th shift -> P=0, cnt_o=0, no done_o.
  - LOAD after 5 shifts -> cnt_o=0, P=par_i.
- With SHIFT_REG_N_ROTATE_EN defined: LOAD 8'h81, then LEFT with rot_i=1 for 1 edge -> P=8'h03, so_o=1. After 8 rotates, P=8'h03 again and done_o has pulsed once.

Source files
------------

// File: rtl/shift_reg_n_pkg.sv
// Shared types and limits for the parametrised universal shift register.
package shift_reg_n_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_LOAD  = 2'd1,
      MODE_LEFT  = 2'd2,
      MODE_RIGHT = 2'd3
   } mode_t;

   localparam int MAX_WIDTH = 64;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_reg_n_cnt.sv
// Frame counter: counts shifts since the last clear/load and pulses done
// for one cycle after the WIDTH-th shift of each frame.
module shift_reg_n_cnt
   import shift_reg_n_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             done_r;
   logic             done_nxt_s;

   // Next counter value; the frame wraps with no gap cycle.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      done_nxt_s = 1'b0;
      if (clr) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (inc) begin
         if (cnt_r == LAST_CNT) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            done_nxt_s = 1'b1;
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter and done pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= {CNT_W{1'b0}};
         done_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   assign cnt  = cnt_r;
   assign done = done_r;

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised universal shift register with registered serial output and
// frame counter. Define SHIFT_REG_N_ROTATE_EN to enable rotate via rot_i.
module shift_reg_n
   import shift_reg_n_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic [1:0]       mode_i,
   input  logic             D,
   input  logic             rot_i,
   input  logic [WIDTH-1:0] par_i,
   output logic [WIDTH-1:0] P,
   output logic             so_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_o
);

   mode_t            mode_s;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] p_nxt_s;
   logic             so_r;
   logic             so_nxt_s;
   logic             left_in_s;
   logic             right_in_s;
   logic             cnt_clr_s;
   logic             cnt_inc_s;

   assign mode_s = mode_t'(mode_i);

`ifdef SHIFT_REG_N_ROTATE_EN
   // Rotate feeds the bit leaving the register back into the vacated end.
   always_comb begin
      if (rot_i) begin
         left_in_s  = p_r[WIDTH-1];
         right_in_s = p_r[0];
      end else begin
         left_in_s  = D;
         right_in_s = D;
      end
   end
`else
   logic unused_rot_s;
   assign unused_rot_s = rot_i;
   assign left_in_s    = D;
   assign right_in_s   = D;
`endif

   // Next data register and serial output for the selected mode.
   always_comb begin
      p_nxt_s  = p_r;
      so_nxt_s = so_r;
      case (mode_s)
         MODE_HOLD: begin
            p_nxt_s  = p_r;
            so_nxt_s = so_r;
         end
         MODE_LOAD: begin
            p_nxt_s  = par_i;
            so_nxt_s = so_r;
         end
         MODE_LEFT: begin
            p_nxt_s  = {p_r[WIDTH-2:0], left_in_s};
            so_nxt_s = p_r[WIDTH-1];
         end
         MODE_RIGHT: begin
            p_nxt_s  = {right_in_s, p_r[WIDTH-1:1]};
            so_nxt_s = p_r[0];
         end
         default: begin
            p_nxt_s  = p_r;
            so_nxt_s = so_r;
         end
      endcase
   end

   // Counter control: clear wins over any shift on the same edge.
   always_comb begin
      cnt_clr_s = clear_i;
      cnt_inc_s = 1'b0;
      if (clear_i) begin
         cnt_inc_s = 1'b0;
      end else begin
         case (mode_s)
            MODE_LOAD:  cnt_clr_s = 1'b1;
            MODE_LEFT:  cnt_inc_s = 1'b1;
            MODE_RIGHT: cnt_inc_s = 1'b1;
            default:    cnt_inc_s = 1'b0;
         endcase
      end
   end

   // Data register and serial output.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_r  <= {WIDTH{1'b0}};
         so_r <= 1'b0;
      end else if (clear_i) begin
         p_r  <= {WIDTH{1'b0}};
         so_r <= 1'b0;
      end else begin
         p_r  <= p_nxt_s;
         so_r <= so_nxt_s;
      end
   end

   shift_reg_n_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr_s),
      .inc  (cnt_inc_s),
      .cnt  (cnt_o),
      .done (done_o)
   );

   assign P    = p_r;
   assign so_o = so_r;

endmodule

// File: tb/tb_shift_reg_n.sv
// Self-checking bench for shift_reg_n (WIDTH=8) against an arithmetic model.
module tb_shift_reg_n;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clear_i = 1'b0;
   logic [1:0]   mode_i = 2'd0;
   logic         D = 1'b0;
   logic         rot_i = 1'b0;
   logic [W-1:0] par_i = 8'h00;
   logic [W-1:0] P;
   logic         so_o;
   logic [3:0]   cnt_o;
   logic         done_o;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   // Reference state as plain integers
   int m_p = 0;
   int m_so = 0;
   int m_cnt = 0;
   int m_done = 0;

   shift_reg_n #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .mode_i  (mode_i),
      .D       (D),
      .rot_i   (rot_i),
      .par_i   (par_i),
      .P       (P),
      .so_o    (so_o),
      .cnt_o   (cnt_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_edge(input int r, input int c, input int m, input int d,
                                      input int rt, input int par);
      int fill;
      if (r != 0 || c != 0) begin
         m_p = 0; m_so = 0; m_cnt = 0; m_done = 0;
      end else if (m == 0) begin
         m_done = 0;
      end else if (m == 1) begin
         m_p = par; m_cnt = 0; m_done = 0;
      end else begin
         if (m == 2) begin
            fill = d;
`ifdef SHIFT_REG_N_ROTATE_EN
            if (rt != 0) fill = m_p / 128;
`endif
            m_so = m_p / 128;
            m_p  = (m_p * 2 + fill) % 256;
         end else begin
            fill = d;
`ifdef SHIFT_REG_N_ROTATE_EN
            if (rt != 0) fill = m_p % 2;
`endif
            m_so = m_p % 2;
            m_p  = m_p / 2 + fill * 128;
         end
         if (m_cnt == W - 1) begin
            m_cnt = 0; m_done = 1;
         end else begin
            m_cnt = m_cnt + 1; m_done = 0;
         end
      end
   endfunction

   task automatic step(input int r, input int c, input int m, input int d,
                       input int rt, input int par);
      rst     = r[0];
      clear_i = c[0];
      mode_i  = m[1:0];
      D       = d[0];
      rot_i   = rt[0];
      par_i   = par[7:0];
      @(posedge clk);
      model_edge(r, c, m, d, rt, par);
      #1;
      if (done_o === 1'b1) done_seen++;
      check_val("P", 64'(P), 64'(m_p));
      check_val("so", 64'(so_o), 64'(m_so));
      check_val("cnt", 64'(cnt_o), 64'(m_cnt));
      check_val("done", 64'(done_o), 64'(m_done));
   endtask

   initial begin
      int pat;
      logic [9:0] stream;
      logic [7:0] so_bits;

      // Reset with LOAD pending has no effect
      step(1, 0, 1, 0, 0, 8'h77);
      step(1, 0, 1, 0, 0, 8'h77);
      check_val("rst_P", 64'(P), 64'h00);
      step(0, 0, 0, 0, 0, 0);
      check_val("rst_hold_P", 64'(P), 64'h00);

      // LEFT frame 1,0,1,0,... -> AA, one done
      done_seen = 0;
      for (int i = 0; i < 8; i++) step(0, 0, 2, (i % 2 == 0) ? 1 : 0, 0, 0);
      check_val("left_frame_P", 64'(P), 64'hAA);
      check_val("left_frame_cnt", 64'(cnt_o), 64'd0);
      check_val("left_frame_done_cnt", 64'(done_seen), 64'd1);
      step(0, 0, 0, 0, 0, 0);
      check_val("left_done_after", 64'(done_o), 64'd0);

      // RIGHT frame after LOAD C3
      step(0, 0, 1, 0, 0, 8'hC3);
      done_seen = 0;
      so_bits = 8'h00;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 3, 0, 0, 0);
         so_bits[i] = so_o;
      end
      check_val("right_frame_P", 64'(P), 64'h00);
      check_val("right_so_seq", 64'(so_bits), 64'hC3);
      check_val("right_done_cnt", 64'(done_seen), 64'd1);

      // Continuous shifting: done every 8 edges with no gap
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 24; i++) begin
         step(0, 0, (i % 3 == 0) ? 3 : 2, $urandom_range(1, 0), 0, 0);
         check_val("cont_done", 64'(done_o), (i % 8 == 7) ? 64'd1 : 64'd0);
      end

      // 10-bit LEFT stream from cnt=0 -> AB, cnt 2
      step(0, 1, 0, 0, 0, 0);
      stream = 10'b1010101011;
      for (int i = 9; i >= 0; i--) step(0, 0, 2, int'(stream[i]), 0, 0);
      check_val("stream10_P", 64'(P), 64'hAB);
      check_val("stream10_cnt", 64'(cnt_o), 64'd2);

      // Clear on the 8th shift wins
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 2, 1, 0, 0);
      step(0, 1, 2, 1, 0, 0);
      check_val("clr8_P", 64'(P), 64'h00);
      check_val("clr8_cnt", 64'(cnt_o), 64'd0);
      check_val("clr8_done", 64'(done_o), 64'd0);
      step(0, 0, 0, 0, 0, 0);
      check_val("clr8_done_next", 64'(done_o), 64'd0);

      // LOAD after 5 shifts
      for (int i = 0; i < 5; i++) step(0, 0, 3, 1, 0, 0);
      step(0, 0, 1, 0, 0, 8'h5A);
      check_val("load5_P", 64'(P), 64'h5A);
      check_val("load5_cnt", 64'(cnt_o), 64'd0);

`ifdef SHIFT_REG_N_ROTATE_EN
      step(0, 0, 1, 0, 0, 8'h81);
      step(0, 0, 2, 0, 1, 0);
      check_val("rot_P", 64'(P), 64'h03);
      check_val("rot_so", 64'(so_o), 64'd1);
      done_seen = 0;
      for (int i = 0; i < 8; i++) step(0, 0, 2, 0, 1, 0);
      check_val("rot8_P", 64'(P), 64'h03);
      check_val("rot8_done_cnt", 64'(done_seen), 64'd1);
`endif

      // Randomized traffic including occasional reset/clear
      for (int i = 0; i < 400; i++) begin
         pat = int'($urandom_range(99, 0));
         step((pat < 2) ? 1 : 0, (pat >= 2 && pat < 5) ? 1 : 0,
              int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
              int'($urandom_range(1, 0)), int'($urandom_range(255, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
